// File: rtl/force_release_sched.sv
// Round-robin sequencer that forces one part-select of a shared port at a time.
// A window is latched at grant, held for hold+1 cycles, then released for one cycle.
module force_release_sched #(
    parameter  int DATA_W = 8,
    parameter  int NREQ   = 2,
    parameter  int CNT_W  = 8,
    localparam int IDX_W  = $clog2(DATA_W)
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic [DATA_W-1:0]       i_d,
    input  logic [NREQ-1:0]         i_req,
    input  logic [NREQ*IDX_W-1:0]   i_lsb,
    input  logic [NREQ*IDX_W-1:0]   i_msb,
    input  logic [NREQ*DATA_W-1:0]  i_val,
    input  logic [NREQ*CNT_W-1:0]   i_hold,
    input  logic [NREQ-1:0]         i_release,
    output logic [NREQ-1:0]         o_gnt,
    output logic [NREQ-1:0]         o_done,
    output logic [NREQ-1:0]         o_err,
    output logic                    o_busy,
    output logic [DATA_W-1:0]       o_force_mask,
    output logic [DATA_W-1:0]       o_q
);

    localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_FORCE   = 2'd1;
    localparam logic [1:0] S_RELEASE = 2'd2;

    logic [1:0]        state;
    logic [PTR_W-1:0]  ptr;
    logic [PTR_W-1:0]  owner;
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] force_val;

    logic              win_ok;
    logic [PTR_W-1:0]  win;
    logic [PTR_W-1:0]  ptr_nxt;
    logic [IDX_W-1:0]  sel_lsb;
    logic [IDX_W-1:0]  sel_msb;
    logic              sel_ok;
    logic [DATA_W-1:0] sel_mask;

    // Scan requesters starting at the pointer; first asserted one wins.
    always_comb begin
        int idx;
        win_ok = 1'b0;
        win    = '0;
        idx    = 0;
        for (int i = 0; i < NREQ; i++) begin
            idx = (int'(ptr) + i) % NREQ;
            if (!win_ok && i_req[idx]) begin
                win_ok = 1'b1;
                win    = PTR_W'(idx);
            end
        end
    end

    always_comb begin
        sel_lsb = i_lsb[int'(win)*IDX_W +: IDX_W];
        sel_msb = i_msb[int'(win)*IDX_W +: IDX_W];
        sel_ok  = (sel_lsb <= sel_msb) && (int'(sel_msb) < DATA_W);
        for (int b = 0; b < DATA_W; b++) begin
            sel_mask[b] = (b >= int'(sel_lsb)) && (b <= int'(sel_msb));
        end
        ptr_nxt = (int'(win) == NREQ - 1) ? '0 : win + 1'b1;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state        <= S_IDLE;
            ptr          <= '0;
            owner        <= '0;
            cnt          <= '0;
            force_val    <= '0;
            o_force_mask <= '0;
            o_gnt        <= '0;
            o_done       <= '0;
            o_err        <= '0;
        end else begin
            o_gnt  <= '0;
            o_done <= '0;
            o_err  <= '0;
            case (state)
                S_IDLE: begin
                    if (win_ok) begin
                        ptr <= ptr_nxt;
                        if (sel_ok) begin
                            state        <= S_FORCE;
                            owner        <= win;
                            o_force_mask <= sel_mask;
                            force_val    <= i_val[int'(win)*DATA_W +: DATA_W] & sel_mask;
                            cnt          <= i_hold[int'(win)*CNT_W +: CNT_W];
                            o_gnt[win]   <= 1'b1;
                        end else begin
                            o_err[win] <= 1'b1;
                        end
                    end
                end
                S_FORCE: begin
                    if (cnt == '0 || i_release[owner]) begin
                        state         <= S_RELEASE;
                        o_force_mask  <= '0;
                        o_done[owner] <= 1'b1;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                S_RELEASE: state <= S_IDLE;
                default:   state <= S_IDLE;
            endcase
        end
    end

    assign o_busy = (state == S_FORCE) || (state == S_RELEASE);
    assign o_q    = (i_d & ~o_force_mask) | (force_val & o_force_mask);

endmodule
